avalon_width_adapter: RTL and testbench
=======================================

// Module: avalon_width_adapter
// PURPOSE
//  Parametrised Avalon-MM width down-converter between a wide slave port, driven by the
//   accelerator masters, and a narrow master port to the SRAM controller.
//  Splits each SLAVE_DW access into R = SLAVE_DW/MASTER_DW consecutive narrow beats.
//  Supports pipelined reads with up to MAX_PEND wide reads outstanding, and per-byte enables.
// PARAMETERS
//  ADDR_W    26  byte address width, both ports
//  SLAVE_DW  32  slave data width; SLAVE_DW/MASTER_DW is a power of 2, >= 2
//  MASTER_DW 16  master data width, multiple of 8
//  MAX_PEND  4   max wide reads accepted but not yet returned, >= 1
// PORTS
//  clock                 in   1            rising-edge clock
//  reset                 in   1            asynchronous, active-low reset
//  slave_address         in   ADDR_W       byte address, SLAVE_DW/8-aligned
//  slave_read/_write     in   1 each       command strobes
//  slave_writedata       in   SLAVE_DW     write data
//  slave_byteenable      in   SLAVE_DW/8   write byte enables
//  slave_waitrequest     out  1            command not accepted this cycle
//  slave_readdata        out  SLAVE_DW     assembled read data
//  slave_readdatavalid   out  1            one-cycle pulse per wide read
//  master_address        out  ADDR_W       narrow beat byte address
//  master_read/_write    out  1 each       narrow command strobes
//  master_writedata      out  MASTER_DW    narrow write data
//  master_byteenable     out  MASTER_DW/8  narrow byte enables; all ones on reads
//  master_readdata       in   MASTER_DW    narrow read data
//  master_readdatavalid  in   1            narrow read beat valid
//  master_waitrequest    in   1            SRAM stall
// BEHAVIOUR
//  Reset values: all outputs 0 except slave_waitrequest = 1. pend_cnt = 0. FSM = IDLE.
//  Command FSM:
//   IDLE: slave_waitrequest = 0 iff (no read pending on the bus) AND (pend_cnt < MAX_PEND,
//    or slave_read = 0).
//   A command is accepted when its strobe is high and slave_waitrequest is low. On accept:
//    latch address, data and byte enables; beat = 0; go to ISSUE.
//   If slave_read and slave_write are both high, write is accepted; read must be held.
//   ISSUE: drive the master strobe with beat slice.
//    Address = base + beat*(MASTER_DW/8).
//    Data/BE slice = bits [SLAVE_DW-1-beat*MASTER_DW -: MASTER_DW]; the first beat carries
//     the most-significant half.
//    A beat completes in the cycle strobe = 1 and master_waitrequest = 0.
//    Hold address, data and strobe unchanged while stalled.
//    After beat R-1 completes, return to IDLE. Strobe drops in that same clock edge, so
//     there are no back-to-back duplicate beats.
//  Read accept increments pend_cnt. Return of a wide word decrements it.
//  Simultaneous increment and decrement leaves pend_cnt unchanged.
//  Read assembly, sub-module:
//   Shift master_readdata in at the LSB side.
//   After the R-th beat, slave_readdata is registered and slave_readdatavalid pulses for
//    1 cycle. Latency is 1 cycle after the last beat.
//   Beat counter wraps to 0.
//   master_readdatavalid with pend_cnt = 0 (e.g. stale after reset) is discarded.
//  Responses return in order. The SRAM controller guarantees in-order completion.
//  Reset mid-operation: strobes drop immediately and counters clear. In-flight narrow
//   beats are not replayed.
// CONFIGURATION
//  AVALON_WIDTH_ADAPTER_SKIP_ZERO_BE_EN
//   Defined: write beats whose BE slice is all zero are not issued, and advance 0 cycles.
//    A write with slave_byteenable = 0 completes in IDLE with no master activity.
//   Undefined: all R write beats are issued, including those with master_byteenable = 0.
// STRUCTURE
//  Package avalon_width_adapter_pkg:
//   cmd_state_t {IDLE, ISSUE}
//   localparams RATIO and BEAT_BYTES
//   function beat_slice()
//  Sub-module avalon_rd_assembler: beat counter, shift register, output register, valid pulse.
// TESTING  (SLAVE_DW=32, MASTER_DW=16, MAX_PEND=4)
//  Write 0x100, data 0xAABBCCDD, BE 4'hF, no stall:
//   -> beats @0x100 data 0xAABB and @0x102 data 0xCCDD, BE 2'b11.
//   -> slave_waitrequest low again in 3rd cycle.
//  Read 0x200, memory returns 0x1234 then 0x5678 with 3-cycle latency:
//   -> slave_readdata 0x12345678.
//   -> single valid pulse 1 cycle after the 2nd beat.
//  5 back-to-back reads, memory responses delayed 20 cycles:
//   -> 4 accepted, the 5th waitrequested until the first response.
//   -> 5 ordered responses.
//  master_waitrequest high 3 cycles on beat 1 of a write:
//   -> beat held stable, 0x102 issued exactly once.
//  Write BE 4'b0011:
//   -> with _EN: only beat @0x102 issued.
//   -> without _EN: beat @0x100 with BE 2'b00, then @0x102.
//  Reset pulsed mid-read, stray master_readdatavalid afterwards:
//   -> outputs at reset values, no slave_readdatavalid.

Source files
------------

// File: rtl/avalon_width_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_width_adapter_pkg
// Description : Shared types, default widths and beat slicing helper for the
//               Avalon-MM width down-converter.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_width_adapter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } cmd_state_t;

    localparam int DEF_SLAVE_DW  = 32;
    localparam int DEF_MASTER_DW = 16;

    // Beat count and beat size of the default configuration
    localparam int RATIO      = DEF_SLAVE_DW / DEF_MASTER_DW;
    localparam int BEAT_BYTES = DEF_MASTER_DW / 8;

    localparam int c_slice_max_w = 1024;

    // Beat 0 is the most-significant slice; caller truncates to slice_w bits.
    function automatic logic [c_slice_max_w-1:0] beat_slice(
        input logic [c_slice_max_w-1:0] word,
        input int                       beat,
        input int                       slice_w,
        input int                       word_w
    );
        return word >> (word_w - (beat + 1) * slice_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_rd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : avalon_rd_assembler
// Description : Collects narrow read beats into one wide word (first beat ends
//               up most significant) and pulses the wide read valid.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_rd_assembler #(
    parameter int SLAVE_DW  = 32,
    parameter int MASTER_DW = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_rdata_valid,
    input  logic [MASTER_DW-1:0] i_rdata,
    input  logic                 i_pend_nz,
    output logic [SLAVE_DW-1:0]  o_readdata,
    output logic                 o_readdatavalid,
    output logic                 o_word_done
);

    localparam int c_ratio = SLAVE_DW / MASTER_DW;
    localparam int c_bw    = $clog2(c_ratio);
    localparam int c_sh_w  = SLAVE_DW - MASTER_DW;

    logic [c_bw-1:0]   r_beat;
    logic [c_sh_w-1:0] r_shift;
    logic              w_take;
    logic              w_last;

    // Beats arriving with nothing outstanding are stale and dropped
    assign w_take      = i_rdata_valid & i_pend_nz;
    assign w_last      = w_take & (r_beat == c_bw'(c_ratio - 1));
    assign o_word_done = w_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_beat          <= '0;
            r_shift         <= '0;
            o_readdata      <= '0;
            o_readdatavalid <= 1'b0;
        end else begin
            o_readdatavalid <= w_last;
            if (w_take) begin
                if (w_last) begin
                    o_readdata <= {r_shift, i_rdata};
                    r_beat     <= '0;
                end else begin
                    r_shift <= c_sh_w'({r_shift, i_rdata});
                    r_beat  <= r_beat + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/avalon_width_adapter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_width_adapter
// Description : Avalon-MM width down-converter: each wide slave access becomes
//               SLAVE_DW/MASTER_DW narrow master beats, pipelined reads.
//               Option macro AVALON_WIDTH_ADAPTER_SKIP_ZERO_BE_EN: write beats
//               with an all-zero byte-enable slice are not issued.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_width_adapter
    import avalon_width_adapter_pkg::*;
#(
    parameter int ADDR_W    = 26,
    parameter int SLAVE_DW  = DEF_SLAVE_DW,
    parameter int MASTER_DW = DEF_MASTER_DW,
    parameter int MAX_PEND  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      slave_address,
    input  logic                   slave_read,
    input  logic                   slave_write,
    input  logic [SLAVE_DW-1:0]    slave_writedata,
    input  logic [SLAVE_DW/8-1:0]  slave_byteenable,
    output logic                   slave_waitrequest,
    output logic [SLAVE_DW-1:0]    slave_readdata,
    output logic                   slave_readdatavalid,
    output logic [ADDR_W-1:0]      master_address,
    output logic                   master_read,
    output logic                   master_write,
    output logic [MASTER_DW-1:0]   master_writedata,
    output logic [MASTER_DW/8-1:0] master_byteenable,
    input  logic [MASTER_DW-1:0]   master_readdata,
    input  logic                   master_readdatavalid,
    input  logic                   master_waitrequest
);

    localparam int c_ratio      = SLAVE_DW / MASTER_DW;
    localparam int c_beat_bytes = MASTER_DW / 8;
    localparam int c_sbe        = SLAVE_DW / 8;
    localparam int c_bw         = $clog2(c_ratio);
    localparam int c_pw         = $clog2(MAX_PEND + 1);

    cmd_state_t        r_state;
    logic              r_rdy;
    logic [c_bw-1:0]   r_beat;
    logic [ADDR_W-1:0] r_base;
    logic [SLAVE_DW-1:0] r_wdata;
    logic [c_sbe-1:0]  r_be;
    logic              r_is_write;
    logic [c_pw-1:0]   r_pend;

    logic              w_accept;
    logic              w_pend_inc;
    logic              w_beat_done;
    logic              w_rd_done;
    int                w_first;
    int                w_next;
    int                w_src_beat;
    int                w_src_idx;
    logic              w_src_write;
    logic [ADDR_W-1:0] w_src_base;
    logic [SLAVE_DW-1:0] w_src_data;
    logic [c_sbe-1:0]  w_src_be;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [MASTER_DW-1:0] w_ld_data;
    logic [c_beat_bytes-1:0] w_ld_be;

`ifdef AVALON_WIDTH_ADAPTER_SKIP_ZERO_BE_EN
    // First beat at or after 'start' with a non-zero BE slice; c_ratio if none
    function automatic int next_beat(input logic [c_sbe-1:0] be, input int start);
        int idx = c_ratio;
        for (int i = c_ratio - 1; i >= 0; i--) begin
            if (i >= start &&
                c_beat_bytes'(beat_slice(c_slice_max_w'(be), i, c_beat_bytes, c_sbe)) != '0)
                idx = i;
        end
        return idx;
    endfunction
`endif

    // Waitrequest is low only in IDLE once out of reset; reads also need a free slot
    assign slave_waitrequest = ~r_rdy | (slave_read & (r_pend >= c_pw'(MAX_PEND)));

    always_comb begin
        w_accept    = (slave_read | slave_write) & ~slave_waitrequest;
        w_pend_inc  = w_accept & ~slave_write;
        w_beat_done = (master_read | master_write) & ~master_waitrequest;
`ifdef AVALON_WIDTH_ADAPTER_SKIP_ZERO_BE_EN
        w_first = slave_write ? next_beat(slave_byteenable, 0) : 0;
        w_next  = r_is_write ? next_beat(r_be, int'(r_beat) + 1) : int'(r_beat) + 1;
`else
        w_first = 0;
        w_next  = int'(r_beat) + 1;
`endif
        if (r_state == IDLE) begin
            w_src_write = slave_write;
            w_src_base  = slave_address;
            w_src_data  = slave_writedata;
            w_src_be    = slave_byteenable;
            w_src_beat  = w_first;
        end else begin
            w_src_write = r_is_write;
            w_src_base  = r_base;
            w_src_data  = r_wdata;
            w_src_be    = r_be;
            w_src_beat  = w_next;
        end
        w_src_idx = (w_src_beat < c_ratio) ? w_src_beat : 0;
        w_ld_addr = w_src_base + ADDR_W'(w_src_idx * c_beat_bytes);
        w_ld_data = MASTER_DW'(beat_slice(c_slice_max_w'(w_src_data), w_src_idx,
                                          MASTER_DW, SLAVE_DW));
        w_ld_be   = w_src_write
                  ? c_beat_bytes'(beat_slice(c_slice_max_w'(w_src_be), w_src_idx,
                                             c_beat_bytes, c_sbe))
                  : '1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state           <= IDLE;
            r_rdy             <= 1'b0;
            r_beat            <= '0;
            r_base            <= '0;
            r_wdata           <= '0;
            r_be              <= '0;
            r_is_write        <= 1'b0;
            r_pend            <= '0;
            master_address    <= '0;
            master_read       <= 1'b0;
            master_write      <= 1'b0;
            master_writedata  <= '0;
            master_byteenable <= '0;
        end else begin
            case ({w_pend_inc, w_rd_done})
                2'b10:   r_pend <= r_pend + c_pw'(1);
                2'b01:   r_pend <= r_pend - c_pw'(1);
                default: r_pend <= r_pend;
            endcase

            case (r_state)
                IDLE: begin
                    r_rdy <= 1'b1;
                    if (w_accept) begin
                        r_base     <= slave_address;
                        r_wdata    <= slave_writedata;
                        r_be       <= slave_byteenable;
                        r_is_write <= slave_write;
                        // A write with nothing to issue completes right here
                        if (w_first < c_ratio) begin
                            r_state           <= ISSUE;
                            r_rdy             <= 1'b0;
                            r_beat            <= c_bw'(w_first);
                            master_address    <= w_ld_addr;
                            master_read       <= ~slave_write;
                            master_write      <= slave_write;
                            master_writedata  <= w_ld_data;
                            master_byteenable <= w_ld_be;
                        end
                    end
                end
                ISSUE: begin
                    if (w_beat_done) begin
                        if (w_next >= c_ratio) begin
                            r_state      <= IDLE;
                            r_rdy        <= 1'b1;
                            master_read  <= 1'b0;
                            master_write <= 1'b0;
                        end else begin
                            r_beat            <= c_bw'(w_next);
                            master_address    <= w_ld_addr;
                            master_writedata  <= w_ld_data;
                            master_byteenable <= w_ld_be;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    avalon_rd_assembler #(
        .SLAVE_DW  (SLAVE_DW),
        .MASTER_DW (MASTER_DW)
    ) u_rd_assembler (
        .clock           (clock),
        .reset           (reset),
        .i_rdata_valid   (master_readdatavalid),
        .i_rdata         (master_readdata),
        .i_pend_nz       (r_pend != '0),
        .o_readdata      (slave_readdata),
        .o_readdatavalid (slave_readdatavalid),
        .o_word_done     (w_rd_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_avalon_width_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_width_adapter
// Description : Self-checking bench: transaction-level model of the converter
//               plus directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_width_adapter;

    localparam int ADDR_W = 26;
    localparam int SDW    = 32;
    localparam int MDW    = 16;
    localparam int MAXP   = 4;
    localparam int R      = SDW / MDW;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] slave_address;
    logic              slave_read, slave_write;
    logic [SDW-1:0]    slave_writedata;
    logic [SDW/8-1:0]  slave_byteenable;
    logic              slave_waitrequest;
    logic [SDW-1:0]    slave_readdata;
    logic              slave_readdatavalid;
    logic [ADDR_W-1:0] master_address;
    logic              master_read, master_write;
    logic [MDW-1:0]    master_writedata;
    logic [MDW/8-1:0]  master_byteenable;
    logic [MDW-1:0]    master_readdata;
    logic              master_readdatavalid;
    logic              master_waitrequest;

    avalon_width_adapter #(
        .ADDR_W(ADDR_W), .SLAVE_DW(SDW), .MASTER_DW(MDW), .MAX_PEND(MAXP)
    ) dut (
        .clock(clock), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_byteenable(slave_byteenable),
        .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid),
        .master_address(master_address), .master_read(master_read),
        .master_write(master_write), .master_writedata(master_writedata),
        .master_byteenable(master_byteenable), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic              wr;
        logic [MDW-1:0]    d;
        logic [1:0]        be;
    } beat_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] a;
        logic [SDW-1:0]    d;
        logic [3:0]        be;
    } cmd_t;

    typedef struct packed {
        int             due;
        logic [MDW-1:0] d;
    } mem_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    cmd_t  cmdq[$];
    beat_t expq[$];
    mem_t  memq[$];
    logic [MDW-1:0] mem_preset[$];
    beat_t blog[$];
    int    blog_cyc[$];
    logic [SDW-1:0] rlog[$];
    int    rlog_cyc[$];
    int    acc_cyc[$];
    logic  wq_hist[int];

    int   outstanding = 0;
    int   asm_cnt = 0;
    logic [SDW-1:0] asm_word = '0;
    logic exp_rv = 1'b0;
    logic [SDW-1:0] exp_rd = '0;
    logic rst_prev = 1'b1;
    logic want_rst = 1'b1;
    logic presenting = 1'b0;
    int   gap_pct = 0, stall_pct = 0, mem_lat = 3, lat_rand = 0, last_due = 0;
    int   stall_left = 0;
    logic [ADDR_W-1:0] stall_addr = '0;

`ifdef AVALON_WIDTH_ADAPTER_SKIP_ZERO_BE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, check and advance the model 1 ns later
    task automatic cycle();
        mem_t m;
        beat_t b;
        cmd_t c;
        logic exp_wait, rv_nx;
        logic [SDW-1:0] rd_nx;
        int lat;
        @(negedge clock);
        reset = ~want_rst;
        if (want_rst) presenting = 1'b0;
        if (!presenting && cmdq.size() != 0 && !want_rst && $urandom_range(99) >= gap_pct)
            presenting = 1'b1;
        if (presenting) begin
            c = cmdq[0];
            slave_read = c.rd; slave_write = c.wr; slave_address = c.a;
            slave_writedata = c.d; slave_byteenable = c.be;
        end else begin
            slave_read = 1'b0; slave_write = 1'b0;
        end
        master_waitrequest = ($urandom_range(99) < stall_pct);
        if (stall_left > 0 && master_write && master_address == stall_addr) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata = memq[0].d;
            void'(memq.pop_front());
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata = 16'($urandom);
        end
        #1;
        wq_hist[cyc] = slave_waitrequest;
        if (!reset) begin
            check("rst_waitrequest", 64'(slave_waitrequest), 64'd1);
            check("rst_outputs", 64'({master_read, master_write, master_address, master_writedata,
                                      master_byteenable, slave_readdatavalid}), 64'd0);
            check("rst_readdata", 64'(slave_readdata), 64'd0);
            expq.delete(); cmdq.delete();
            outstanding = 0; asm_cnt = 0; exp_rv = 1'b0; rst_prev = 1'b1;
        end else begin
            check("readdatavalid", 64'(slave_readdatavalid), 64'(exp_rv));
            if (exp_rv) check("readdata", 64'(slave_readdata), 64'(exp_rd));
            if (slave_readdatavalid) begin
                rlog.push_back(slave_readdata);
                rlog_cyc.push_back(cyc);
            end
            rv_nx = 1'b0; rd_nx = '0;
            exp_wait = rst_prev || expq.size() != 0 || (slave_read && outstanding >= MAXP);
            check("waitrequest", 64'(slave_waitrequest), 64'(exp_wait));
            check("strobes", 64'({master_read, master_write}),
                  expq.size() == 0 ? 64'd0 : (expq[0].wr ? 64'd1 : 64'd2));
            if (expq.size() != 0 && (master_read || master_write)) begin
                check("beat_addr", 64'(master_address), 64'(expq[0].a));
                check("beat_be", 64'(master_byteenable), 64'(expq[0].be));
                if (expq[0].wr) check("beat_data", 64'(master_writedata), 64'(expq[0].d));
                if (!master_waitrequest) begin
                    b = expq.pop_front();
                    blog.push_back(b);
                    blog_cyc.push_back(cyc);
                    if (!b.wr) begin
                        lat = lat_rand ? int'($urandom_range(1, 6)) : mem_lat;
                        m.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                        m.d = (mem_preset.size() != 0) ? mem_preset.pop_front() : 16'($urandom);
                        memq.push_back(m);
                        last_due = m.due;
                    end
                end
            end
            if (master_readdatavalid && outstanding > 0) begin
                asm_word = {asm_word[SDW-MDW-1:0], master_readdata};
                asm_cnt++;
                if (asm_cnt == R) begin
                    rv_nx = 1'b1; rd_nx = asm_word; asm_cnt = 0; outstanding--;
                end
            end
            if ((slave_read || slave_write) && !exp_wait) begin
                acc_cyc.push_back(cyc);
                c = cmdq[0];
                if (c.wr) begin
                    for (int i = 0; i < R; i++) begin
                        b.a  = c.a + ADDR_W'(2 * i);
                        b.wr = 1'b1;
                        b.d  = MDW'(c.d >> (MDW * (R - 1 - i)));
                        b.be = 2'(c.be >> (2 * (R - 1 - i)));
                        if (!(SKIP && b.be == 2'b00)) expq.push_back(b);
                    end
                    if (c.rd) cmdq[0].wr = 1'b0;
                    else begin void'(cmdq.pop_front()); presenting = 1'b0; end
                end else begin
                    for (int i = 0; i < R; i++) begin
                        b.a = c.a + ADDR_W'(2 * i); b.wr = 1'b0; b.d = '0; b.be = 2'b11;
                        expq.push_back(b);
                    end
                    outstanding++;
                    void'(cmdq.pop_front());
                    presenting = 1'b0;
                end
            end
            exp_rv = rv_nx; exp_rd = rd_nx; rst_prev = 1'b0;
        end
        cyc++;
    endtask

    function automatic logic idle();
        return cmdq.size() == 0 && expq.size() == 0 && memq.size() == 0 &&
               outstanding == 0 && !exp_rv;
    endfunction

    task automatic drain(input int max_cyc);
        int n = 0;
        while (!idle() && n < max_cyc) begin cycle(); n++; end
        if (!idle()) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max_cyc);
        end
        repeat (2) cycle();
    endtask

    initial begin
        int n0, r0, k0, a, cnt;
        cmd_t c;
        reset = 1'b0; slave_read = 1'b0; slave_write = 1'b0; slave_address = '0;
        slave_writedata = '0; slave_byteenable = '0; master_waitrequest = 1'b0;
        master_readdatavalid = 1'b0; master_readdata = '0;
        repeat (3) cycle();
        want_rst = 1'b0;

        // Plain 2-beat write
        n0 = blog.size();
        cmdq.push_back('{rd:1'b0, wr:1'b1, a:26'h100, d:32'hAABBCCDD, be:4'hF});
        drain(50);
        check("t1_nbeats", 64'(blog.size() - n0), 64'd2);
        check("t1_beat0", 64'({blog[n0].a, blog[n0].d, blog[n0].be}), 64'({26'h100, 16'hAABB, 2'b11}));
        check("t1_beat1", 64'({blog[n0+1].a, blog[n0+1].d, blog[n0+1].be}), 64'({26'h102, 16'hCCDD, 2'b11}));
        a = acc_cyc[$];
        check("t1_wait_busy", 64'(wq_hist[a+2]), 64'd1);
        check("t1_wait_free", 64'(wq_hist[a+3]), 64'd0);

        // Read with fixed 3-cycle memory latency
        n0 = blog.size(); r0 = rlog.size();
        mem_preset.push_back(16'h1234); mem_preset.push_back(16'h5678); mem_lat = 3;
        cmdq.push_back('{rd:1'b1, wr:1'b0, a:26'h200, d:32'h0, be:4'h0});
        drain(50);
        check("t2_nresp", 64'(rlog.size() - r0), 64'd1);
        check("t2_data", 64'(rlog[r0]), 64'h12345678);
        check("t2_beat1_addr", 64'(blog[n0+1].a), 64'h202);
        check("t2_latency", 64'(rlog_cyc[r0] - blog_cyc[n0+1]), 64'd4);

        // Five reads against a slow memory: the fifth waits for a free slot
        k0 = acc_cyc.size(); r0 = rlog.size(); mem_lat = 20;
        for (int i = 0; i < 5; i++)
            cmdq.push_back('{rd:1'b1, wr:1'b0, a:26'(32'h400 + 4 * i), d:32'h0, be:4'h0});
        drain(300);
        check("t3_nacc", 64'(acc_cyc.size() - k0), 64'd5);
        check("t3_nresp", 64'(rlog.size() - r0), 64'd5);
        check("t3_fifth_acc", 64'(acc_cyc[k0+4]), 64'(rlog_cyc[r0]));

        // Three stall cycles on the second write beat
        n0 = blog.size(); stall_addr = 26'h102; stall_left = 3;
        cmdq.push_back('{rd:1'b0, wr:1'b1, a:26'h100, d:32'h0F0E0D0C, be:4'hF});
        drain(50);
        cnt = 0;
        for (int i = n0; i < blog.size(); i++) if (blog[i].a == 26'h102) cnt++;
        check("t4_once", 64'(cnt), 64'd1);
        check("t4_gap", 64'(blog_cyc[n0+1] - blog_cyc[n0]), 64'd4);

        // Partial and empty byte enables
        n0 = blog.size();
        cmdq.push_back('{rd:1'b0, wr:1'b1, a:26'h300, d:32'h11223344, be:4'b0011});
        drain(50);
        if (SKIP) begin
            check("t5_nbeats", 64'(blog.size() - n0), 64'd1);
            check("t5_beat", 64'({blog[n0].a, blog[n0].d, blog[n0].be}), 64'({26'h302, 16'h3344, 2'b11}));
        end else begin
            check("t5_nbeats", 64'(blog.size() - n0), 64'd2);
            check("t5_beat0", 64'({blog[n0].a, blog[n0].be}), 64'({26'h300, 2'b00}));
            check("t5_beat1", 64'({blog[n0+1].a, blog[n0+1].d, blog[n0+1].be}), 64'({26'h302, 16'h3344, 2'b11}));
        end
        n0 = blog.size();
        cmdq.push_back('{rd:1'b0, wr:1'b1, a:26'h310, d:32'hDEADBEEF, be:4'b0000});
        drain(50);
        check("t5_zero_be", 64'(blog.size() - n0), SKIP ? 64'd0 : 64'd2);

        // Reset while a read is in flight; stale beats arrive afterwards
        n0 = blog.size(); mem_lat = 8;
        cmdq.push_back('{rd:1'b1, wr:1'b0, a:26'h500, d:32'h0, be:4'h0});
        for (int i = 0; i < 20 && blog.size() - n0 < 2; i++) cycle();
        repeat (2) cycle();
        want_rst = 1'b1;
        repeat (2) cycle();
        want_rst = 1'b0;
        r0 = rlog.size();
        repeat (20) cycle();
        check("t6_no_valid", 64'(rlog.size() - r0), 64'd0);
        check("t6_stale_drained", 64'(memq.size()), 64'd0);

        // Randomized mixed traffic
        gap_pct = 30; stall_pct = 25; lat_rand = 1;
        for (int i = 0; i < 250; i++) begin
            int sel;
            sel = int'($urandom_range(99));
            c.a  = 26'($urandom) & 26'h3FFFFFC;
            c.d  = $urandom;
            c.be = 4'($urandom);
            c.rd = (sel < 40) || (sel >= 95);
            c.wr = (sel >= 40);
            if (sel >= 85 && sel < 95) c.be = ($urandom_range(1) == 0) ? 4'h0 : c.be;
            cmdq.push_back(c);
        end
        drain(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
